rob_ctrl: RTL

Allocation, completion-tracking and in-order retire controller for the 64-entry reorder buffer. Owns the head (retire) and tail (allocate) pointers, the per-entry valid and complete bits, and the occupancy count. It hands out ROB indices to dispatch, marks entries complete from the four issue-lane completion ports, retires up to two entries per cycle in program order, and sequences drain and flush.

---
 rtl/rob_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rob_ctrl.sv
// Reorder-buffer control: allocation, completion tracking, in-order dual retire,
// drain and flush sequencing for a DEPTH-entry ROB.
module rob_ctrl #(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 dispatch_req,
  output logic                 dispatch_ack,
  output logic [IDX_W-1:0]     alloc_idx,
  output logic                 stall,
  input  logic [3:0]           complete_vld,
  input  logic [4*IDX_W-1:0]   complete_idx,
  output logic                 retire_vld_0,
  output logic                 retire_vld_1,
  output logic [IDX_W-1:0]     retire_idx_0,
  output logic [IDX_W-1:0]     retire_idx_1,
  input  logic                 drain_req,
  output logic                 drain_done,
  input  logic                 flush_req,
  output logic [IDX_W:0]       count,
  output logic                 full,
  output logic                 empty
);

  localparam int CW = IDX_W + 1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_FLUSH} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   head_q, head_d, head_p1;
  logic [IDX_W-1:0]   tail_q, tail_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [DEPTH-1:0]   cmpl_q, cmpl_d;
  logic [CW-1:0]      count_d;
  logic               r0, r1, ret0, ret1;
  logic               drain_done_d;

  assign head_p1      = head_q + IDX_W'(1);
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign r0           = valid_q[head_q] & cmpl_q[head_q];
  assign r1           = r0 & valid_q[head_p1] & cmpl_q[head_p1];
  // The flush edge suppresses retire strobes even if the head was ready.
  assign ret0         = r0 & ~flush_req;
  assign ret1         = r1 & ~flush_req;
  assign dispatch_ack = dispatch_req & (state_q == ST_RUN) & ~full;
  assign stall        = dispatch_req & ~dispatch_ack;
  assign alloc_idx    = tail_q;

  always_comb begin
    state_d      = state_q;
    drain_done_d = 1'b0;
    if (flush_req) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_RUN:   if (drain_req) state_d = ST_DRAIN;
        ST_DRAIN: if (count == '0) begin
                    state_d      = ST_RUN;
                    drain_done_d = 1'b1;
                  end
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    cmpl_d  = cmpl_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count;
    if (flush_req) begin
      valid_d = '0;
      cmpl_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (state_q != ST_FLUSH) begin
        for (int unsigned k = 0; k < 4; k++) begin
          if (complete_vld[k] && valid_q[complete_idx[k*IDX_W +: IDX_W]])
            cmpl_d[complete_idx[k*IDX_W +: IDX_W]] = 1'b1;
        end
      end
      // Retire clears after completions so a late completion cannot revive a retired slot.
      if (r0) begin
        valid_d[head_q] = 1'b0;
        cmpl_d[head_q]  = 1'b0;
      end
      if (r1) begin
        valid_d[head_p1] = 1'b0;
        cmpl_d[head_p1]  = 1'b0;
      end
      head_d = head_q + IDX_W'(r0) + IDX_W'(r1);
      if (dispatch_ack) begin
        valid_d[tail_q] = 1'b1;
        cmpl_d[tail_q]  = 1'b0;
        tail_d          = tail_q + IDX_W'(1);
      end
      count_d = count + CW'(dispatch_ack) - CW'(r0) - CW'(r1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_RUN;
      head_q       <= '0;
      tail_q       <= '0;
      valid_q      <= '0;
      cmpl_q       <= '0;
      count        <= '0;
      drain_done   <= 1'b0;
      retire_vld_0 <= 1'b0;
      retire_vld_1 <= 1'b0;
      retire_idx_0 <= '0;
      retire_idx_1 <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      valid_q      <= valid_d;
      cmpl_q       <= cmpl_d;
      count        <= count_d;
      drain_done   <= drain_done_d;
      retire_vld_0 <= ret0;
      retire_vld_1 <= ret1;
      retire_idx_0 <= ret0 ? head_q : '0;
      retire_idx_1 <= ret1 ? head_p1 : '0;
    end
  end

endmodule
